// File: rtl/dlx_trace_monitor.sv
// dlx_trace_monitor
//   Follows a DLX fetch stream through a PIPE_DEPTH-stage instruction delay
//   line. It decodes the word that retires from the last stage into an R/I/J
//   trace record and buffers the records in a small FIFO for a consumer that
//   uses a valid/ready handshake.
//
//   Ports
//     clk, rst           : clock (rising edge), asynchronous active-low reset
//     iw_in              : fetched instruction word, sampled on non-stall edges
//     stall              : freezes the delay line, the warm-up counter and pushes
//     data_in            : result value paired with the retiring instruction
//     filter_nop         : when high, no record is made for a NOP (opcode 0x15)
//     trace_ready        : consumer accepts the head record
//     trace_valid        : FIFO holds at least one record
//     trace_type..data   : fields of the head record (all zero while empty)
//     overflow           : sticky, set when a record was dropped on a full FIFO
//     drop_count         : saturating count of dropped records
module dlx_trace_monitor #(
  parameter int IR_SIZE    = 32,
  parameter int WORD       = 32,
  parameter int PIPE_DEPTH = 5,
  parameter int WARMUP     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IR_SIZE-1:0] iw_in,
  input  logic               stall,
  input  logic [WORD-1:0]    data_in,
  input  logic               filter_nop,
  input  logic               trace_ready,
  output logic               trace_valid,
  output logic [1:0]         trace_type,
  output logic [5:0]         trace_opcode,
  output logic [4:0]         trace_rs1,
  output logic [4:0]         trace_rs2,
  output logic [4:0]         trace_rd,
  output logic [25:0]        trace_imm,
  output logic [WORD-1:0]    trace_data,
  output logic               overflow,
  output logic [7:0]         drop_count
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int WW    = $clog2(WARMUP + 1);
  localparam int REC_W = 2 + 6 + 5 + 5 + 5 + 26 + WORD;

  localparam logic [WW-1:0] WARM_MAX = WW'(WARMUP);
  localparam logic [PW:0]   DEPTH_V  = (PW+1)'(FIFO_DEPTH);

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_NOP = 6'h15;

  localparam logic [1:0] T_R = 2'd0;
  localparam logic [1:0] T_I = 2'd1;
  localparam logic [1:0] T_J = 2'd2;

  logic [IR_SIZE-1:0] stage_q [PIPE_DEPTH];
  logic [IR_SIZE-1:0] stage_d [PIPE_DEPTH];
  logic [WW-1:0]      warm_q, warm_d;
  logic [REC_W-1:0]   mem_q [FIFO_DEPTH];
  logic [REC_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PW:0]        wr_q, wr_d, rd_q, rd_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         drop_q, drop_d;

  logic [IR_SIZE-1:0] ret_iw;
  logic [5:0]         op;
  logic [1:0]         typ;
  logic [4:0]         rs1, rs2, rd;
  logic [25:0]        imm;
  logic [WORD-1:0]    rec_data;
  logic [REC_W-1:0]   rec, head;
  logic               warm_done, empty, full, push, pop, wr_en, drop;

  // Decode of the word leaving the last delay-line stage.
  always_comb begin
    ret_iw = stage_q[PIPE_DEPTH-1];
    op     = ret_iw[IR_SIZE-1 -: 6];
    typ    = T_I;
    rs1    = ret_iw[25:21];
    rs2    = '0;
    rd     = ret_iw[20:16];
    imm    = {10'd0, ret_iw[15:0]};
    if (op == OP_R) begin
      typ = T_R;
      rs2 = ret_iw[20:16];
      rd  = ret_iw[15:11];
      imm = '0;
    end else if (op == OP_J || op == OP_JAL) begin
      typ = T_J;
      rs1 = '0;
      rd  = '0;
      imm = ret_iw[25:0];
    end
    // NOP records never carry a result value.
    rec_data = (op == OP_NOP) ? '0 : data_in;
    rec      = {typ, op, rs1, rs2, rd, imm, rec_data};
  end

  // Pointers carry one extra bit so that full and empty are distinguishable.
  always_comb begin
    warm_done = (warm_q == WARM_MAX);
    empty     = (wr_q == rd_q);
    full      = ((wr_q - rd_q) == DEPTH_V);
    push      = !stall && warm_done && !(filter_nop && op == OP_NOP);
    pop       = !empty && trace_ready;
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    wr_en     = push && (!full || pop);
    drop      = push && full && !pop;
  end

  always_comb begin
    stage_d = stage_q;
    warm_d  = warm_q;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (!stall) begin
      stage_d[0] = iw_in;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
      if (!warm_done) begin
        warm_d = warm_q + WW'(1);
      end
    end
    if (wr_en) begin
      mem_d[wr_q[PW-1:0]] = rec;
      wr_d                = wr_q + (PW+1)'(1);
    end
    if (pop) begin
      rd_d = rd_q + (PW+1)'(1);
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        stage_q[k] <= '0;
      end
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_q[k] <= '0;
      end
      warm_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      stage_q <= stage_d;
      mem_q   <= mem_d;
      warm_q  <= warm_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Outputs read as zero while the FIFO is empty.
  always_comb begin
    head = empty ? '0 : mem_q[rd_q[PW-1:0]];
  end

  assign {trace_type, trace_opcode, trace_rs1, trace_rs2, trace_rd,
          trace_imm, trace_data} = head;
  assign trace_valid = !empty;
  assign overflow    = ovf_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_dlx_trace_monitor.sv
module tb_dlx_trace_monitor;

  localparam int PD = 5;
  localparam int WU = 8;
  localparam int FD = 4;
  localparam logic [31:0] NOP_W = 32'h5400_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iw_in;
  logic        stall;
  logic [31:0] data_in;
  logic        filter_nop;
  logic        trace_ready;
  logic        trace_valid;
  logic [1:0]  trace_type;
  logic [5:0]  trace_opcode;
  logic [4:0]  trace_rs1, trace_rs2, trace_rd;
  logic [25:0] trace_imm;
  logic [31:0] trace_data;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_assert = 0;
  int n_fail   = 0;

  dlx_trace_monitor #(
    .IR_SIZE(32), .WORD(32), .PIPE_DEPTH(PD), .WARMUP(WU), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .iw_in(iw_in), .stall(stall), .data_in(data_in),
    .filter_nop(filter_nop), .trace_ready(trace_ready),
    .trace_valid(trace_valid), .trace_type(trace_type),
    .trace_opcode(trace_opcode), .trace_rs1(trace_rs1), .trace_rs2(trace_rs2),
    .trace_rd(trace_rd), .trace_imm(trace_imm), .trace_data(trace_data),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: instruction history as a queue, records as a queue.
  typedef struct packed {
    logic [1:0]  t;
    logic [5:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [25:0] imm;
    logic [31:0] data;
  } rec_t;

  rec_t        mq[$];
  logic [31:0] hist[$];
  int          m_warm;
  bit          m_ovf;
  int          m_drops;

  function automatic rec_t mk(input logic [31:0] iw, input logic [31:0] d);
    rec_t r;
    r.op = iw[31:26];
    if (r.op == 6'h00) begin
      r.t = 2'd0; r.rs1 = iw[25:21]; r.rs2 = iw[20:16]; r.rd = iw[15:11]; r.imm = '0;
    end else if (r.op == 6'h02 || r.op == 6'h03) begin
      r.t = 2'd2; r.rs1 = '0; r.rs2 = '0; r.rd = '0; r.imm = iw[25:0];
    end else begin
      r.t = 2'd1; r.rs1 = iw[25:21]; r.rs2 = '0; r.rd = iw[20:16]; r.imm = {10'd0, iw[15:0]};
    end
    r.data = (r.op == 6'h15) ? 32'd0 : d;
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    hist.delete();
    for (int i = 0; i < PD; i++) hist.push_back(32'd0);
    m_warm  = 0;
    m_ovf   = 0;
    m_drops = 0;
  endtask

  task automatic model_edge();
    logic [31:0] ret;
    bit do_pop, do_push;
    ret     = hist[PD-1];
    do_pop  = (mq.size() != 0) && trace_ready;
    do_push = !stall && (m_warm == WU) && !(filter_nop && ret[31:26] == 6'h15);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      if (mq.size() < FD) mq.push_back(mk(ret, data_in));
      else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end
    if (!stall) begin
      hist.push_front(iw_in);
      void'(hist.pop_back());
      if (m_warm < WU) m_warm++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    rec_t e;
    e = (mq.size() != 0) ? mq[0] : '0;
    chk({ph, "_valid"}, 32'(trace_valid), 32'(mq.size() != 0));
    chk({ph, "_type"},  32'(trace_type),   32'(e.t));
    chk({ph, "_op"},    32'(trace_opcode), 32'(e.op));
    chk({ph, "_rs1"},   32'(trace_rs1),    32'(e.rs1));
    chk({ph, "_rs2"},   32'(trace_rs2),    32'(e.rs2));
    chk({ph, "_rd"},    32'(trace_rd),     32'(e.rd));
    chk({ph, "_imm"},   32'(trace_imm),    32'(e.imm));
    chk({ph, "_data"},  trace_data,        e.data);
    chk({ph, "_ovf"},   32'(overflow),     32'(m_ovf));
    chk({ph, "_drops"}, 32'(drop_count),   32'(m_drops));
  endtask

  task automatic tick(input string ph);
    model_edge();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic flush(input int n);
    iw_in = NOP_W; filter_nop = 1'b1; trace_ready = 1'b1; stall = 1'b0;
    for (int i = 0; i < n; i++) tick("flush");
  endtask

  initial begin
    logic [31:0] r32;
    logic [5:0]  rop;
    rst = 1'b0; iw_in = '0; stall = 1'b0; data_in = '0;
    filter_nop = 1'b0; trace_ready = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b1;

    // Warm-up window and first ADDI record.
    iw_in = 32'h2022_0005; data_in = 32'd7; trace_ready = 1'b1;
    for (int i = 1; i <= WU; i++) begin
      tick("warm");
      chk("warm_novalid", 32'(trace_valid), 32'd0);
    end
    tick("first");
    chk("first_valid", 32'(trace_valid), 32'd1);
    chk("first_type",  32'(trace_type), 32'd1);
    chk("first_op",    32'(trace_opcode), 32'h08);
    chk("first_rs1",   32'(trace_rs1), 32'd1);
    chk("first_rd",    32'(trace_rd), 32'd2);
    chk("first_imm",   32'(trace_imm), 32'd5);
    chk("first_data",  trace_data, 32'd7);

    // R-type latency: visible after the 6th edge counted from capture.
    flush(PD + FD + 1);
    iw_in = 32'h00A6_3820; data_in = 32'h1234;
    tick("r_cap");
    iw_in = NOP_W;
    for (int i = 0; i < PD - 1; i++) begin
      tick("r_lat");
      chk("r_lat_novalid", 32'(trace_valid), 32'd0);
    end
    tick("r_out");
    chk("r_valid", 32'(trace_valid), 32'd1);
    chk("r_type",  32'(trace_type), 32'd0);
    chk("r_rs1",   32'(trace_rs1), 32'd5);
    chk("r_rs2",   32'(trace_rs2), 32'd6);
    chk("r_rd",    32'(trace_rd), 32'd7);

    // J-type record.
    flush(PD + FD + 1);
    iw_in = 32'h0800_0010;
    tick("j_cap");
    iw_in = NOP_W;
    for (int i = 0; i < PD; i++) tick("j_lat");
    chk("j_type", 32'(trace_type), 32'd2);
    chk("j_imm",  32'(trace_imm), 32'h10);
    chk("j_regs", 32'({trace_rs1, trace_rs2, trace_rd}), 32'd0);

    // NOP recorded when the filter is off; carries zero data.
    flush(PD + FD + 1);
    filter_nop = 1'b0; data_in = 32'hDEAD;
    tick("nop_rec");
    chk("nop_valid", 32'(trace_valid), 32'd1);
    chk("nop_op",    32'(trace_opcode), 32'h15);
    chk("nop_data",  trace_data, 32'd0);

    // Six pushes into a stalled consumer: four kept, two dropped.
    flush(PD + FD + 1);
    trace_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      iw_in = 32'h2022_0000 | 32'(i + 1); data_in = 32'(100 + i);
      tick("ovf_fill");
    end
    iw_in = NOP_W;
    for (int i = 0; i < PD; i++) tick("ovf_wait");
    chk("ovf_flag",  32'(overflow), 32'd1);
    chk("ovf_drops", 32'(drop_count), 32'd2);
    trace_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", 32'(trace_imm), 32'(i + 1));
      tick("ovf_drain");
    end
    chk("ovf_empty", 32'(trace_valid), 32'd0);

    // Full FIFO with simultaneous push/pop, then a 3-cycle stall.
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iw_in = 32'h2022_0010 | 32'(i + 1);
      tick("full_fill");
    end
    iw_in = NOP_W;
    for (int i = 0; i < PD - 1; i++) tick("full_wait");
    trace_ready = 1'b1;
    tick("full_pp");
    chk("full_pp_drops", 32'(drop_count), 32'd2);
    trace_ready = 1'b0; stall = 1'b1; iw_in = 32'h2022_0077;
    for (int i = 0; i < 3; i++) tick("stall");
    chk("stall_head", 32'(trace_imm), 32'h12);
    stall = 1'b0; iw_in = NOP_W; trace_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("full_order", 32'(trace_imm), 32'h12 + 32'(i));
      tick("full_drain");
    end
    chk("full_empty", 32'(trace_valid), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r32 = $urandom();
      case ($urandom_range(0, 4))
        0: rop = 6'h00;
        1: rop = 6'h02;
        2: rop = 6'h03;
        3: rop = 6'h15;
        default: rop = 6'($urandom());
      endcase
      iw_in       = {rop, r32[25:0]};
      data_in     = $urandom();
      stall       = ($urandom_range(0, 3) == 0);
      trace_ready = 1'($urandom_range(0, 1));
      filter_nop  = 1'($urandom_range(0, 1));
      tick("rand");
    end

    // Asynchronous reset with three records buffered.
    flush(PD + FD + 1);
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iw_in = 32'h2022_0020 | 32'(i); tick("rst_fill");
    end
    iw_in = NOP_W;
    for (int i = 0; i < PD; i++) tick("rst_wait");
    chk("rst_pre_valid", 32'(trace_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_valid_drop", 32'(trace_valid), 32'd0);
    chk("rst_ovf_drop",   32'(overflow), 32'd0);
    model_reset();
    check_all("rst_async");
    #2;
    rst = 1'b1;
    iw_in = 32'h2022_0005; data_in = 32'd9; trace_ready = 1'b1;
    for (int i = 0; i < WU; i++) begin
      tick("rewarm");
      chk("rewarm_novalid", 32'(trace_valid), 32'd0);
    end
    tick("rewarm_first");
    chk("rewarm_valid", 32'(trace_valid), 32'd1);
    chk("rewarm_data",  trace_data, 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dlx_trace_monitor.md
DLX_TRACE_MONITOR -- requirements
Module: dlx_trace_monitor

Interface
REQ-001 SHALL have parameter IR_SIZE, default 32, instruction word width.
REQ-002 SHALL have parameter WORD, default 32, data width.
REQ-003 SHALL have parameter PIPE_DEPTH, default 5, instruction delay-line stages (>=1).
REQ-004 SHALL have parameter WARMUP, default 8, non-stall cycles ignored after reset.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, trace records buffered (power of 2).
REQ-006 SHALL have port clk  in  1  single clock, rising edge; the block uses one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-008 SHALL have port iw_in  in  IR_SIZE  fetched instruction word, sampled every non-stall edge.
REQ-009 SHALL have port stall  in  1  freezes delay line, warm-up counter and push.
REQ-010 SHALL have port data_in  in  WORD  result value paired with the retiring instruction.
REQ-011 SHALL have port filter_nop  in  1  suppress NOP records when high.
REQ-012 SHALL have port trace_ready  in  1  consumer accepts head record.
REQ-013 SHALL have port trace_valid  out  1  head record valid.
REQ-014 SHALL have ports trace_type out 2 (0=R,1=I,2=J, 3 never), trace_opcode out 6, trace_rs1/trace_rs2/trace_rd out 5 each, trace_imm out 26, trace_data out WORD, all from the FIFO head.
REQ-015 SHALL have port overflow  out  1  sticky: a record was dropped.
REQ-016 SHALL have port drop_count  out  8  dropped-record count, saturating.

Function
REQ-017 Delay line: on each edge with stall=0, stage0<=iw_in, stage[k]<=stage[k-1]; stall=1 holds all stages.
REQ-018 Warm-up counter: increments on each stall=0 edge, saturates at WARMUP; push is enabled only when counter==WARMUP before the edge.
REQ-019 Decode of stage[PIPE_DEPTH-1]: opcode=bits[IR_SIZE-1:IR_SIZE-6]; opcode 0x00 -> R, 0x02/0x03 -> J, else I.
REQ-020 R: rs1=[25:21], rs2=[20:16], rd=[15:11], imm=0.
REQ-021 I: rs1=[25:21], rd=[20:16], rs2=0, imm=zero-extended [15:0].
REQ-022 J: rs1=rs2=rd=0, imm=[25:0].
REQ-023 Record = {type, opcode, rs1, rs2, rd, imm, data_in}; NOP (opcode 0x15) records carry data=0.
REQ-024 Push occurs on an edge with stall=0, warm-up complete, and not (filter_nop=1 and opcode=0x15).
REQ-025 Pop occurs on an edge with trace_valid=1 and trace_ready=1; head advances next cycle.
REQ-026 trace_valid = FIFO not empty; outputs stable while trace_valid=1 and trace_ready=0.
REQ-027 Latency: word presented on iw_in before capture edge E1, no stalls, FIFO empty, warm -> trace_valid high after edge E(PIPE_DEPTH+1).
REQ-028 FIFO full and push with no pop: record dropped, overflow<=1, drop_count+1 saturating at 255; FIFO contents unchanged.
REQ-029 FIFO full, simultaneous push and pop: both performed, no drop, occupancy unchanged.
REQ-030 FIFO empty, pop impossible (trace_valid=0); simultaneous push on empty: record visible next cycle.
REQ-031 Read/write pointers wrap modulo FIFO_DEPTH; occupancy tracked with one extra bit.

Reset
REQ-032 rst=0 asynchronously clears delay line to 0, warm-up counter, FIFO pointers, overflow, drop_count; trace_valid=0 and all trace_* outputs=0.
REQ-033 Reset mid-operation discards all buffered records; after rst=1 the full WARMUP window reapplies.
REQ-034 overflow and drop_count cleared only by reset.

Verification
REQ-035 Defaults, rst released, iw_in=0x20220005 (ADDI) held from edge 1, data_in=7, trace_ready=1 -> no trace_valid before edge 9; first record type=1, opcode=0x08, rs1=1, rd=2, imm=5, data=7.
REQ-036 iw_in=0x00A63820 (R) after warm-up -> trace_valid after 6th edge from capture, rs1=5, rs2=6, rd=7, type=0.
REQ-037 iw_in=0x0800_0010 (J) -> type=2, imm=0x10, regs 0; opcode 0x15 with filter_nop=1 -> no record; filter_nop=0 -> record with data=0.
REQ-038 trace_ready=0, 6 pushes -> 4 stored, overflow=1, drop_count=2; then ready=1 -> 4 records in order.
REQ-039 FIFO full, push and pop same edge -> drop_count unchanged, occupancy 4; stall=1 for 3 cycles -> no pushes, delay line frozen, record order intact.
REQ-040 rst=0 asserted between edges with 3 records buffered -> trace_valid and overflow fall immediately, no records for WARMUP edges after release.
